fe_fetch_buf: RTL
=================

# fe_fetch_buf

Fetch buffer between the front-end fetch controller and the instruction cache. Holds a small fully-associative set of instruction lines. Answers fetch requests combinationally on a hit. Issues one line fill at a time to the I-cache on a miss. Supports bulk invalidation (fence.i / self-modifying code).

## Interface

**Parameters**
- `FB_ENTRIES`, 4 — number of line entries; power of two, ≥2.
- `LINE_BYTES`, 64 — line size; power of two, ≥8; instructions per line = `LINE_BYTES/4`.

**Ports** (clock and reset first)
- `clk` — input, 1 — single clock. All state changes on posedge.
- `reset` — input, 1 — synchronous, active-high.
- `fe_fb_req_fb0` — input, `t_fe_fb_req` — fetch request from the fetch controller: `valid`, `addr` (`t_paddr`), `id`.
- `fb_fe_rsp_fb0` — output, `t_fb_fe_rsp` — same-cycle response: `valid`, `instr` (`t_rv_instr`), `pc` (`t_paddr`).
- `fb_inv` — input, 1 — invalidate all entries; discard any in-flight fill.
- `fb_ic_req_valid` — output, 1 — line fill request.
- `fb_ic_req_addr` — output, `t_paddr` — line-aligned fill address.
- `ic_fb_req_ready` — input, 1 — I-cache accepts the request this cycle.
- `ic_fb_rsp_valid` — input, 1 — fill data returning.
- `ic_fb_rsp_data` — input, `LINE_BYTES*8` — line data; word 0 in bits [31:0].

## Operation

**Entry state**
- Each entry holds `valid`, line tag `addr[$bits(t_paddr)-1:log2(LINE_BYTES)]` and data.
- Reset: all entries invalid.

**Lookup (combinational)**
- Hit = `fe_fb_req_fb0.valid` & some valid entry with matching tag.
- On hit, `fb_fe_rsp_fb0.valid`=1.
- `instr` = word `addr[log2(LINE_BYTES)-1:2]` of the hit entry.
- `pc` = request `addr`.
- `addr[1:0]` are ignored.
- At most one entry may match. Bench asserts onehot0 of the match vector.
- On miss or no request, `fb_fe_rsp_fb0` is all-zero.

**Fill FSM** (states `FB_IDLE`, `FB_REQ`, `FB_WAIT`)
- `FB_IDLE` → `FB_REQ` when:
  - a valid request misses, and
  - `fb_inv`=0.
- Latch the line address into `fill_addr`.
- `FB_REQ`:
  - Drive `fb_ic_req_valid`=1 and `fb_ic_req_addr`=`fill_addr`.
  - Valid and address are held stable until `ic_fb_req_ready`, then go to `FB_WAIT`.
  - No withdrawal: `fb_inv` does not drop the request.
- `FB_WAIT`:
  - On `ic_fb_rsp_valid`, install the line into the victim entry unless `discard`=1.
  - Go to `FB_IDLE`, or to `FB_REQ` for a prefetch (see Configuration).
- `ic_fb_rsp_valid` outside `FB_WAIT` is illegal; bench asserts on it.
- Misses while not `FB_IDLE` issue nothing new. Fetch re-requests every cycle and hits once the fill lands.

**Victim selection**
- Round-robin pointer, reset 0.
- Advances by 1 (mod `FB_ENTRIES`) after each install.
- An invalid entry, if any exists, is chosen before the pointer, lowest index first.

**Invalidate**
- `fb_inv` clears all valid bits at the next edge.
- If the FSM is in `FB_REQ` or `FB_WAIT`, set `discard`.
- `discard` is cleared when the FSM returns to `FB_IDLE` or starts a new fill.
- `fb_inv` and `ic_fb_rsp_valid` in the same cycle: the fill is discarded.

**Reset mid-fill**
- FSM returns to `FB_IDLE` and `discard` clears.
- The environment guarantees no I-cache response after reset.

## Timing

- Hit latency: 0 cycles (request and response in the same fb0 cycle).
- Miss, no stalls:
  - Request seen in cycle N; `fb_ic_req_valid` in N+1.
  - Response in cycle R; line written at the R edge; hit available in R+1.
  - No bypass from fill data to response.
- A line being replaced still returns its old data in the install cycle.
- Reset values of outputs:
  - `fb_fe_rsp_fb0`=0
  - `fb_ic_req_valid`=0
  - `fb_ic_req_addr`=0

## Configuration

- `FE_FETCH_BUF_NEXT_LINE_PF_EN` defined:
  - When a non-discarded demand fill of line L installs, and line L+1 is not present, the FSM goes directly to `FB_REQ` with `fill_addr`=L+1 (`pf` flag set).
  - L+1 wraps modulo the address width.
  - Prefetch fills install like demand fills.
  - A demand miss during a prefetch waits for it; there is no preemption.
  - A prefetch fill never triggers another prefetch.
- Not defined: after every fill the FSM returns to `FB_IDLE`; no `pf` logic is compiled.

## Test plan

- **Cold miss:**
  - Stimulus: reset, then request addr 0x1000 held; I-cache ready immediately, response 3 cycles later with word0=0x00000013.
  - Required: `fb_ic_req_addr`=0x1000 exactly once; rsp valid with instr 0x00000013, pc 0x1000, one cycle after install.
- **Hit word select:**
  - Stimulus: line 0x1000 filled with word k = 0x100+k; request 0x1024.
  - Required: instr 0x109 in the same cycle; no I-cache request.
- **Replacement:**
  - Stimulus: `FB_ENTRIES`=4; fill lines 0x0, 0x40, 0x80, 0xC0, then request 0x100.
  - Required: entry 0 (line 0x0) evicted; request 0x0 then misses again.
- **Invalidate during fill:**
  - Stimulus: miss on 0x2000, `ready` held low 5 cycles, `fb_inv` pulsed in cycle 2, then ready and response.
  - Required: request held stable until accepted; fill discarded; a new request to 0x2000 is issued afterwards.
- **Invalidate with response in the same cycle:**
  - Stimulus: `fb_inv` and `ic_fb_rsp_valid` asserted together.
  - Required: all entries invalid next cycle; the line is not installed.
- **Prefetch** (macro defined):
  - Stimulus: miss on 0x3000.
  - Required: requests 0x3000 then 0x3040 back-to-back; request 0x3040 hits with no further I-cache traffic. Without the macro, only 0x3000 is requested.

Source files
------------

// File: rtl/fe_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fe_fetch_buf
//  Purpose  : Fully-associative instruction line buffer between the fetch
//             controller and the I-cache. Zero-latency hits, one line fill in
//             flight, bulk invalidate. FE_FETCH_BUF_NEXT_LINE_PF_EN adds a
//             next-line prefetch after each demand fill.
//  Packing  : fe_fb_req_fb0 = {valid, addr[PADDR_W-1:0], id[ID_W-1:0]}
//             fb_fe_rsp_fb0 = {valid, instr[31:0], pc[PADDR_W-1:0]}
//  Revision : 1.0 - initial release
// ============================================================================
module fe_fetch_buf #(
    parameter int FB_ENTRIES = 4,
    parameter int LINE_BYTES = 64,
    parameter int PADDR_W    = 32,
    parameter int ID_W       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PADDR_W+ID_W:0]   fe_fb_req_fb0,
    output logic [32+PADDR_W:0]     fb_fe_rsp_fb0,
    input  logic                    fb_inv,
    output logic                    fb_ic_req_valid,
    output logic [PADDR_W-1:0]      fb_ic_req_addr,
    input  logic                    ic_fb_req_ready,
    input  logic                    ic_fb_rsp_valid,
    input  logic [LINE_BYTES*8-1:0] ic_fb_rsp_data
);
    localparam int c_off_w  = $clog2(LINE_BYTES);
    localparam int c_tag_w  = PADDR_W - c_off_w;
    localparam int c_idx_w  = $clog2(FB_ENTRIES);
    localparam int c_line_w = LINE_BYTES * 8;
    localparam logic [c_idx_w-1:0] c_ptr_one = 1;

    typedef enum logic [1:0] {
        FB_IDLE = 2'd0,
        FB_REQ  = 2'd1,
        FB_WAIT = 2'd2
    } t_fb_state;

    logic                  w_req_valid;
    logic [PADDR_W-1:0]    w_req_addr;
    logic [c_tag_w-1:0]    w_req_tag;
    logic [c_off_w-3:0]    w_word_sel;
    logic                  w_unused_bits;

    logic [FB_ENTRIES-1:0] r_valid;
    logic [c_tag_w-1:0]    r_tag  [FB_ENTRIES];
    logic [c_line_w-1:0]   r_data [FB_ENTRIES];
    logic [c_idx_w-1:0]    r_ptr;
    t_fb_state             r_state, w_state_nxt;
    logic [c_tag_w-1:0]    r_fill_tag, w_fill_tag_nxt;
    logic                  r_discard, w_discard_nxt;

    logic [FB_ENTRIES-1:0] w_match;
    logic                  w_hit;
    logic [c_line_w-1:0]   w_hit_line;
    logic [31:0]           w_instr;
    logic [c_idx_w-1:0]    w_victim;
    logic                  w_install;

    assign w_req_valid   = fe_fb_req_fb0[PADDR_W+ID_W];
    assign w_req_addr    = fe_fb_req_fb0[PADDR_W+ID_W-1:ID_W];
    assign w_req_tag     = w_req_addr[PADDR_W-1:c_off_w];
    assign w_word_sel    = w_req_addr[c_off_w-1:2];
    assign w_unused_bits = ^{fe_fb_req_fb0[ID_W-1:0], w_req_addr[1:0]};

    for (genvar gi = 0; gi < FB_ENTRIES; gi++) begin : g_match
        assign w_match[gi] = r_valid[gi] && (r_tag[gi] == w_req_tag);
    end

    // Tags are unique, so OR-ing the masked lines selects the single hit.
    always_comb begin
        w_hit_line = '0;
        for (int i = 0; i < FB_ENTRIES; i++) begin
            if (w_match[i]) w_hit_line = w_hit_line | r_data[i];
        end
    end

    assign w_hit         = w_req_valid && (|w_match);
    assign w_instr       = w_hit_line[{w_word_sel, 5'b00000} +: 32];
    assign fb_fe_rsp_fb0 = w_hit ? {1'b1, w_instr, w_req_addr} : '0;

    // Lowest-index invalid entry wins over the round-robin pointer.
    always_comb begin
        w_victim = r_ptr;
        for (int i = FB_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_victim = i[c_idx_w-1:0];
        end
    end

    assign w_install = (r_state == FB_WAIT) && ic_fb_rsp_valid && !r_discard && !fb_inv;

`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
    localparam logic [c_tag_w-1:0] c_tag_one = 1;
    logic                  r_pf, w_pf_nxt;
    logic [c_tag_w-1:0]    w_fill_tag_inc;
    logic [FB_ENTRIES-1:0] w_next_match;

    assign w_fill_tag_inc = r_fill_tag + c_tag_one;

    for (genvar gj = 0; gj < FB_ENTRIES; gj++) begin : g_next_match
        assign w_next_match[gj] = r_valid[gj] && (r_tag[gj] == w_fill_tag_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) r_pf <= 1'b0;
        else       r_pf <= w_pf_nxt;
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_tag_nxt = r_fill_tag;
        w_discard_nxt  = r_discard;
`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
        w_pf_nxt       = r_pf;
`endif
        case (r_state)
            FB_IDLE: begin
                w_discard_nxt = 1'b0;
                if (w_req_valid && !(|w_match) && !fb_inv) begin
                    w_state_nxt    = FB_REQ;
                    w_fill_tag_nxt = w_req_tag;
`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
                    w_pf_nxt       = 1'b0;
`endif
                end
            end
            FB_REQ: begin
                if (fb_inv)          w_discard_nxt = 1'b1;
                if (ic_fb_req_ready) w_state_nxt   = FB_WAIT;
            end
            FB_WAIT: begin
                if (fb_inv) w_discard_nxt = 1'b1;
                if (ic_fb_rsp_valid) begin
                    w_state_nxt   = FB_IDLE;
                    w_discard_nxt = 1'b0;
`ifdef FE_FETCH_BUF_NEXT_LINE_PF_EN
                    w_pf_nxt      = 1'b0;
                    // Presence of L+1 is judged on the pre-install contents.
                    if (w_install && !r_pf && !(|w_next_match)) begin
                        w_state_nxt    = FB_REQ;
                        w_fill_tag_nxt = w_fill_tag_inc;
                        w_pf_nxt       = 1'b1;
                    end
`endif
                end
            end
            default: w_state_nxt = FB_IDLE;
        endcase
    end

    assign fb_ic_req_valid = (r_state == FB_REQ);
    assign fb_ic_req_addr  = fb_ic_req_valid ? {r_fill_tag, {c_off_w{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FB_IDLE;
            r_fill_tag <= '0;
            r_discard  <= 1'b0;
            r_valid    <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_tag <= w_fill_tag_nxt;
            r_discard  <= w_discard_nxt;
            if (w_install) begin
                r_valid[w_victim] <= 1'b1;
                r_ptr             <= r_ptr + c_ptr_one;
            end
            if (fb_inv) r_valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_victim]  <= r_fill_tag;
            r_data[w_victim] <= ic_fb_rsp_data;
        end
    end

endmodule
`default_nettype wire
